// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
//
// Bundle between the register file and its users (decode issues reads and
// allocations, writeback issues writes). The register file connects through
// the slave modport; the decode/writeback side connects through master.
//
// Signals:
//   rd_en       NUM_RD          per-port read enable
//   rd_addr     NUM_RD*AW       read addresses, port p at [p*AW +: AW]
//   rd_data     NUM_RD*XLEN     registered read data, port p at [p*XLEN +: XLEN]
//   rd_busy     NUM_RD          registered pending flag of the register read
//   wr_en       1               write enable
//   wr_addr     AW              write address
//   wr_data     XLEN            write data
//   alloc_en    1               mark alloc_addr as having a write in flight
//   alloc_addr  AW              register to mark pending
//   any_pending 1               OR of all pending bits (combinational)
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic                   any_pending;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, any_pending
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, any_pending
  );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Integer register file for the RISC-V core with NUM_RD registered read
// ports, one write port, optional write-to-read bypass, hardwired x0 and a
// per-register pending-write scoreboard for RAW hazard detection on
// multi-cycle writebacks.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_sb_if slave modport (reads, write, allocation, status)
//
// Reset state: every register 0 except x2 = SP_INIT; read outputs 0; no
// register pending.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter int              NUM_RD  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h80000FFC,
  parameter int              BYPASS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  // Address width follows the register count; it is not a free parameter.
  localparam int AW        = $clog2(NREGS);
  localparam bit BYPASS_EN = (BYPASS != 0);

  genvar gi;

  // Current architectural value of every register; x0 is a constant zero.
  logic [XLEN-1:0]  rf_word [NREGS];
  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;

  // -------------------------------------------------------------------------
  // Register storage. Each register has its own asynchronously reset flop so
  // that a reset restores the whole file (including the SP value in x2)
  // without a clear sequence.
  // -------------------------------------------------------------------------
  assign rf_word[0] = '0;

  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      localparam logic [XLEN-1:0] RST_VAL = (gi == 2) ? SP_INIT : '0;
      logic [XLEN-1:0] word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= RST_VAL;
        end else if (bus.wr_en && (bus.wr_addr == AW'(gi))) begin
          word_reg <= bus.wr_data;
        end
      end

      assign rf_word[gi] = word_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Scoreboard. A same-cycle allocation beats the release from writeback:
  // the write retires the previous producer, the allocation belongs to the
  // newly issued one, so the register must stay pending.
  // -------------------------------------------------------------------------
  always_comb begin
    pending_next = pending_reg;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.alloc_en && (bus.alloc_addr == AW'(r))) begin
        pending_next[r] = 1'b1;
      end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
        pending_next[r] = 1'b0;
      end
    end
    // x0 never has a producer in flight.
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign bus.any_pending = |pending_reg;

  // -------------------------------------------------------------------------
  // Read ports. Each port is fully independent; they only share the storage,
  // the bypass source and the scoreboard. The busy flag is taken from the
  // post-update pending vector so it already reflects this cycle's write
  // release and allocation.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_next;
      logic [XLEN-1:0] data_reg;
      logic            busy_next;
      logic            busy_reg;

      assign addr = bus.rd_addr[gi*AW +: AW];

      always_comb begin
        data_next = rf_word[addr];
        busy_next = pending_next[addr];
        if (addr == '0) begin
          data_next = '0;
          busy_next = 1'b0;
        end else if (BYPASS_EN && bus.wr_en && (bus.wr_addr == addr)) begin
          data_next = bus.wr_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else if (bus.rd_en[gi]) begin
          data_reg <= data_next;
          busy_reg <= busy_next;
        end
      end

      assign bus.rd_data[gi*XLEN +: XLEN] = data_reg;
      assign bus.rd_busy[gi]              = busy_reg;
    end
  endgenerate

endmodule
